puf_ro_evaluator: RTL and testbench
===================================

# puf_ro_evaluator

Evaluation core of the inverter PUF, directly upstream of the AXI4-Lite register slave. On a start pulse from the register file it expands a 32-bit challenge into a sequence of oscillator-pair selections and counts edges of the two selected inverter-ring outputs over a programmable window. Each comparison yields one response bit. It returns a RESP_BITS-wide response word and a tie count for the slave to expose as read-only registers.

## Interface
- N_RO, 8: number of ring-oscillator inputs; power of two, ≥ 2; SEL_W = $clog2(N_RO).
- RESP_BITS, 32: response length, 1..32.
- CNT_W, 16: edge-counter and window width.
- clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- ro_in  in  N_RO  raw, asynchronous oscillator outputs.
- start  in  1  one-cycle request from the register file.
- challenge  in  32  LFSR seed; sampled when start is accepted.
- window_cycles  in  CNT_W  count window length; sampled when start is accepted.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle completion pulse.
- response  out  RESP_BITS  result word; bit i is the i-th comparison.
- tie_count  out  6  number of comparisons with equal counts, saturating at 63.

## Operation
- FSM states and transitions:
  - IDLE → SETTLE on start.
  - SETTLE (2 cycles) → COUNT.
  - COUNT (W cycles) → COMPARE.
  - COMPARE (1 cycle) → SETTLE if bits remain, otherwise DONE.
  - DONE (1 cycle) → IDLE.
- Start acceptance:
  - start is accepted only in IDLE. Any start pulse in other states is ignored.
  - On acceptance: latch the seed (challenge == 0 is replaced by 32'h0000_0001), latch W = max(window_cycles, 1), clear response, clear tie_count, set the bit index to 0.
- LFSR: 32-bit Galois, right shift, taps 32'h8020_0003.
  - next = (l >> 1) ^ (l[0] ? taps : 0).
  - Advanced exactly once per COMPARE.
- Pair selection, held constant from SETTLE through COMPARE for each bit:
  - sel_a = l[SEL_W-1:0]; sel_b = l[2*SEL_W-1:SEL_W].
  - If sel_b == sel_a, then sel_b = sel_a ^ 1.
- Each channel: N_RO:1 mux of ro_in → 2-FF synchronizer → rising-edge detect → CNT_W saturating counter.
  - Counters and synchronizers clear during SETTLE, which flushes mux-switch glitches.
  - Counters increment only in COUNT.
- COMPARE: response[idx] = (cnt_a > cnt_b). If cnt_a == cnt_b, write bit 0 and increment tie_count (saturating).
- response and tie_count hold their value from DONE until the next accepted start.

## Timing
- Reset values: busy 0, done 0, response 0, tie_count 0, state IDLE, counters 0.
- Start accepted in cycle t: busy = 1 from t+1.
- Each bit takes W+3 cycles (2 SETTLE + W COUNT + 1 COMPARE).
- done is high exactly in cycle t+1+RESP_BITS·(W+3). busy is 0 in that same cycle.
- response is valid and stable in the done cycle.
- A start in the done cycle is ignored; IDLE is re-entered the next cycle.
- Edge-count quantisation: at most one edge per 2 clocks. Faster oscillators alias, which is acceptable.
- Reset mid-evaluation: next cycle is IDLE with all outputs at reset values. No done pulse is issued.
- Counter at 2^CNT_W−1 holds its value (no wrap).

## Structure
- puf_pkg holds:
  - the state enum;
  - LFSR_TAPS = 32'h8020_0003;
  - function lfsr_next;
  - function pick_pair (returns sel_a and sel_b).
- Sub-module puf_ro_counter: 2-FF sync, edge detect and saturating counter, with clear/enable inputs. Instantiated twice (channels A and B); the muxes live in the parent.

## Test plan
- Bench oscillator model: ro_in[k] toggles every k+2 clocks, so lower index = faster. Expected values come from a reference model of lfsr_next and pick_pair.
- Challenge 0, W=64, RESP_BITS=32:
  - seed is forced to 1; first pair (1,0) → response[0] = 0;
  - done exactly at t+1+32·67;
  - full word matches the model.
- Challenge 32'hDEAD_BEEF, W=256 → response matches the model bit-for-bit; tie_count = 0.
- All ro_in tied low, W=16 → response = 0, tie_count = 32, busy/done timing unchanged.
- window_cycles = 0 → treated as 1; done at t+1+32·4.
- Second start pulse while busy, plus a start in the done cycle → both ignored; a single done pulse only.
- Reset asserted mid-COUNT of bit 5 → next cycle busy = 0, done = 0, response = 0; a fresh start yields the same result as the uninterrupted run.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF evaluator.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_COMPARE,
    ST_DONE
  } state_t;

  // Oscillator-pair selection; fields are wide enough for any N_RO up to 256.
  typedef struct packed {
    logic [7:0] sel_a;
    logic [7:0] sel_b;
  } pair_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // 32-bit Galois LFSR, right shift.
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : '0);
  endfunction

  // Low SEL_W bits pick channel A, the next SEL_W bits channel B; a pair that
  // would compare a ring against itself is split by flipping B's LSB.
  function automatic pair_t pick_pair(input logic [31:0] l, input int unsigned sel_w);
    logic [31:0] mask;
    pair_t       p;
    mask    = (32'd1 << sel_w) - 32'd1;
    p.sel_a = 8'(l & mask);
    p.sel_b = 8'((l >> sel_w) & mask);
    if (p.sel_b == p.sel_a) p.sel_b = p.sel_a ^ 8'd1;
    return p;
  endfunction

endpackage

// File: rtl/puf_ro_counter.sv
// One measurement channel: 2-FF synchronizer, rising-edge detect and a
// saturating edge counter. clear flushes both the synchronizer and the count.
module puf_ro_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ro,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic sync1, sync2, sync3;
  logic rise;

  assign rise = sync2 & ~sync3;

  // Synchronize the raw ring output and count its rising edges while enabled.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      count <= '0;
    end else begin
      sync1 <= ro;
      sync2 <= sync1;
      sync3 <= sync2;
      if (enable && rise && (count != '1)) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/puf_ro_evaluator.sv
// PUF evaluation core: expands a challenge into oscillator-pair selections,
// counts edges of each pair over a programmable window and builds a response.
module puf_ro_evaluator
  import puf_pkg::*;
#(
  parameter int N_RO      = 8,
  parameter int RESP_BITS = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_RO-1:0]      ro_in,
  input  logic                 start,
  input  logic [31:0]          challenge,
  input  logic [CNT_W-1:0]     window_cycles,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [5:0]           tie_count
);

  localparam int unsigned SEL_W = $clog2(N_RO);
  localparam int unsigned IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  state_t           state, state_nx;
  logic [31:0]      lfsr;
  logic [CNT_W-1:0] win;
  logic [CNT_W-1:0] tmr;
  logic [IDX_W-1:0] idx;
  logic             last_bit;
  logic             settle_end, count_end;
  pair_t            pair;
  logic             ro_a, ro_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  assign pair       = pick_pair(lfsr, SEL_W);
  assign last_bit   = (idx == IDX_W'(RESP_BITS - 1));
  assign settle_end = (tmr == CNT_W'(1));
  assign count_end  = (tmr == win - 1'b1);
  assign busy       = (state == ST_SETTLE) || (state == ST_COUNT) || (state == ST_COMPARE);
  assign done       = (state == ST_DONE);

  // Route the two selected oscillators to their measurement channels.
  always_comb begin
    ro_a = 1'b0;
    ro_b = 1'b0;
    for (int unsigned k = 0; k < N_RO; k++) begin
      if (pair.sel_a == 8'(k)) ro_a = ro_in[k];
      if (pair.sel_b == 8'(k)) ro_b = ro_in[k];
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start) state_nx = ST_SETTLE;
      ST_SETTLE:  if (settle_end) state_nx = ST_COUNT;
      ST_COUNT:   if (count_end) state_nx = ST_COMPARE;
      ST_COMPARE: state_nx = last_bit ? ST_DONE : ST_SETTLE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Datapath: capture the request, time the phases, record each comparison.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr      <= 32'h0000_0001;
      win       <= CNT_W'(1);
      tmr       <= '0;
      idx       <= '0;
      response  <= '0;
      tie_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lfsr      <= (challenge == '0) ? 32'h0000_0001 : challenge;
            win       <= (window_cycles == '0) ? CNT_W'(1) : window_cycles;
            tmr       <= '0;
            idx       <= '0;
            response  <= '0;
            tie_count <= '0;
          end
        end
        ST_SETTLE: tmr <= settle_end ? '0 : tmr + 1'b1;
        ST_COUNT:  tmr <= count_end ? '0 : tmr + 1'b1;
        ST_COMPARE: begin
          response[idx] <= (cnt_a > cnt_b);
          if ((cnt_a == cnt_b) && (tie_count != '1)) tie_count <= tie_count + 6'd1;
          lfsr <= lfsr_next(lfsr);
          idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  puf_ro_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clock  (clock),
    .reset  (reset),
    .ro     (ro_a),
    .clear  (state == ST_SETTLE),
    .enable (state == ST_COUNT),
    .count  (cnt_a)
  );

  puf_ro_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clock  (clock),
    .reset  (reset),
    .ro     (ro_b),
    .clear  (state == ST_SETTLE),
    .enable (state == ST_COUNT),
    .count  (cnt_b)
  );

endmodule

// File: tb/tb_puf_ro_evaluator.sv
// Directed bench for puf_ro_evaluator with a cycle-accurate oscillator model.
module tb_puf_ro_evaluator;

  logic        clock;
  logic        reset;
  logic [7:0]  ro_in;
  logic        start;
  logic [31:0] challenge;
  logic [15:0] window_cycles;
  logic        busy;
  logic        done;
  logic [31:0] response;
  logic [5:0]  tie_count;

  int  vectors     = 0;
  int  miscompares = 0;
  bit  ro_hold     = 1'b0;

  puf_ro_evaluator #(.N_RO(8), .RESP_BITS(32), .CNT_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .ro_in         (ro_in),
    .start         (start),
    .challenge     (challenge),
    .window_cycles (window_cycles),
    .busy          (busy),
    .done          (done),
    .response      (response),
    .tie_count     (tie_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle c ends at the posedge at time 10c+5; its negedge is at time 10c.
  function automatic int cyc();
    return int'($time / 10);
  endfunction

  function automatic bit ro_at(int c, int k);
    return ((c / (k + 2)) % 2) == 1;
  endfunction

  // Ring k toggles every k+2 cycles; driven on the negedge, sampled on the posedge.
  always @(negedge clock) begin
    for (int k = 0; k < 8; k++) ro_in[k] = ro_hold ? 1'b0 : ro_at(cyc(), k);
  end

  // Value seen through the flushed synchronizer of the bit whose SETTLE starts at b.
  function automatic bit mx(int t, int b, int k, bit hold);
    return (!hold && t >= b + 2) ? ro_at(t, k) : 1'b0;
  endfunction

  function automatic int mcnt(int b, int w, int k, bit hold);
    int n = 0;
    for (int c = b + 2; c <= b + 1 + w; c++)
      if (mx(c - 2, b, k, hold) && !mx(c - 3, b, k, hold)) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_next(logic [31:0] l);
    logic [31:0] r;
    r = {1'b0, l[31:1]};
    if (l[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic model(input logic [31:0] seed, input int w, input int t, input bit hold,
                       output logic [31:0] resp, output logic [5:0] tie);
    logic [31:0] l;
    logic [2:0]  a, bsel;
    int we, base, ca, cb;
    l    = (seed == 32'd0) ? 32'd1 : seed;
    we   = (w == 0) ? 1 : w;
    resp = '0;
    tie  = '0;
    for (int i = 0; i < 32; i++) begin
      a    = l[2:0];
      bsel = l[5:3];
      if (bsel == a) bsel = a ^ 3'd1;
      base = t + 1 + i * (we + 3);
      ca   = mcnt(base, we, int'(a), hold);
      cb   = mcnt(base, we, int'(bsel), hold);
      resp[i] = (ca > cb);
      if (ca == cb && tie != 6'd63) tie = tie + 6'd1;
      l = m_next(l);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full evaluation; extra issues a start while busy and one in the done cycle.
  task automatic run(input string tag, input logic [31:0] ch, input int w, input bit hold,
                     input bit extra, output logic [31:0] got);
    logic [31:0] er;
    logic [5:0]  et;
    int t, td, we, ndone, first_done;
    we = (w == 0) ? 1 : w;
    @(negedge clock);
    challenge     = ch;
    window_cycles = 16'(w);
    start         = 1'b1;
    t             = cyc();
    model(ch, w, t, hold, er, et);
    td = t + 1 + 32 * (we + 3);
    ndone = 0;
    first_done = -1;
    @(negedge clock);
    start = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    while (cyc() <= td + 2) begin
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = cyc();
      end
      if (cyc() == td) begin
        check({tag, " response"}, 64'(response), 64'(er));
        check({tag, " tie_count"}, 64'(tie_count), 64'(et));
        check({tag, " busy_in_done"}, 64'(busy), 64'd0);
        check({tag, " done_at_t"}, 64'(done), 64'd1);
        got = response;
      end
      if (cyc() == td + 1) begin
        check({tag, " idle_after_done"}, 64'(busy), 64'd0);
        check({tag, " response_held"}, 64'(response), 64'(er));
      end
      start = extra && (cyc() == t + 10 || cyc() == td);
      @(negedge clock);
    end
    start = 1'b0;
    check({tag, " done_pulses"}, 64'(ndone), 64'd1);
    check({tag, " done_cycle"}, 64'(first_done), 64'(td));
  endtask

  logic [31:0] r;
  int          t0, nd;

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    challenge     = '0;
    window_cycles = '0;
    ro_in         = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_response", 64'(response), 64'd0);
    check("reset_tie", 64'(tie_count), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run("zero_seed", 32'd0, 64, 1'b0, 1'b0, r);
    check("zero_seed bit0", 64'(r[0]), 64'd0);

    run("deadbeef", 32'hDEAD_BEEF, 256, 1'b0, 1'b0, r);

    ro_hold = 1'b1;
    repeat (2) @(negedge clock);
    run("tied_low", 32'h1357_9BDF, 16, 1'b1, 1'b0, r);
    check("tied_low resp_zero", 64'(response), 64'd0);
    check("tied_low tie32", 64'(tie_count), 64'd32);
    ro_hold = 1'b0;
    repeat (2) @(negedge clock);

    run("win0", 32'h1234_5678, 0, 1'b0, 1'b0, r);

    run("extra_starts", 32'hCAFE_F00D, 8, 1'b0, 1'b1, r);

    // Abort in the middle of bit 5's counting window.
    @(negedge clock);
    challenge     = 32'hA5A5_0F0F;
    window_cycles = 16'd64;
    start         = 1'b1;
    t0            = cyc();
    @(negedge clock);
    start = 1'b0;
    repeat (5 * 67 + 20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset response", 64'(response), 64'd0);
    check("midreset tie", 64'(tie_count), 64'd0);
    nd = 0;
    repeat (300) begin
      @(negedge clock);
      if (done || busy) nd++;
    end
    check("midreset no_activity", 64'(nd), 64'd0);
    run("after_reset", 32'hA5A5_0F0F, 64, 1'b0, 1'b0, r);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
